shift_pipe4: RTL

//   4-stage pipelined 16-bit barrel shifter for the execute datapath, with valid/ready handshakes.

---
 rtl/shift_pipe4.sv | 205 ++++++++++++++++++++
 1 files changed

// File: rtl/shift_pipe4.sv
// shift_pipe4: four-stage pipelined 16-bit barrel shifter with valid/ready
// handshakes on both sides and a sideband tag that travels with each operation.
// Stage k applies a shift/rotate by 2^k when Cnt[k] is set, so the by-8 stage is last.
//
// Optional feature: define SHIFT_PIPE_ZFLAG_EN to add the out_zero output, a
// registered "result is zero" flag held in the last stage next to the result.
//
// Handshake: a transfer happens on a rising edge where valid and ready are both
// high. The source holds its payload while valid is high and ready is low. Ready
// never depends on the same side's valid, so there is no combinational loop.
module shift_pipe4 #(
    parameter int WIDTH = 16,   // only 16 is supported: Cnt is 4 bits wide
    parameter int TAG_W = 3
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] In,
    input  logic [3:0]       Cnt,
    input  logic [1:0]       Op,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] Out,
    output logic [TAG_W-1:0] out_tag
`ifdef SHIFT_PIPE_ZFLAG_EN
    ,
    output logic             out_zero
`endif
);

    localparam logic [1:0] OP_ROL = 2'b00;
    localparam logic [1:0] OP_SLL = 2'b01;
    localparam logic [1:0] OP_ROR = 2'b10;
    localparam logic [1:0] OP_SRL = 2'b11;

    // One conditional shift/rotate step by a fixed amount.
    function automatic logic [WIDTH-1:0] stage_shift(
        input logic [WIDTH-1:0] d,
        input logic [1:0]       op,
        input logic             en,
        input int               amt
    );
        logic [WIDTH-1:0] r;
        r = d;
        if (en) begin
            case (op)
                OP_ROL:  r = (d << amt) | (d >> (WIDTH - amt));
                OP_SLL:  r = d << amt;
                OP_ROR:  r = (d >> amt) | (d << (WIDTH - amt));
                default: r = d >> amt; // OP_SRL, zero fill
            endcase
        end
        return r;
    endfunction

    // Stage registers. Each stage keeps only the Cnt bits still needed
    // downstream; the last stage needs neither Cnt nor Op any more.
    logic             s0_valid_q;
    logic [WIDTH-1:0] s0_data_q;
    logic [3:1]       s0_cnt_q;
    logic [1:0]       s0_op_q;
    logic [TAG_W-1:0] s0_tag_q;

    logic             s1_valid_q;
    logic [WIDTH-1:0] s1_data_q;
    logic [3:2]       s1_cnt_q;
    logic [1:0]       s1_op_q;
    logic [TAG_W-1:0] s1_tag_q;

    logic             s2_valid_q;
    logic [WIDTH-1:0] s2_data_q;
    logic             s2_cnt_q;     // original Cnt[3]
    logic [1:0]       s2_op_q;
    logic [TAG_W-1:0] s2_tag_q;

    logic             s3_valid_q;
    logic [WIDTH-1:0] s3_data_q;
    logic [TAG_W-1:0] s3_tag_q;
`ifdef SHIFT_PIPE_ZFLAG_EN
    logic             s3_zero_q;
`endif

    // Next data values entering each stage.
    logic [WIDTH-1:0] s0_data_d;
    logic [WIDTH-1:0] s1_data_d;
    logic [WIDTH-1:0] s2_data_d;
    logic [WIDTH-1:0] s3_data_d;

    // Per-stage load enables: a stage loads when empty or when the stage after it
    // moves, so bubbles collapse during a stall.
    logic ready0;
    logic ready1;
    logic ready2;
    logic ready3;

    // Ready chain from the output back to the input.
    always_comb begin
        ready3 = !s3_valid_q || out_ready;
        ready2 = !s2_valid_q || ready3;
        ready1 = !s1_valid_q || ready2;
        ready0 = !s0_valid_q || ready1;
    end

    // Shift network: the step by 2^k is applied on the way into stage k.
    always_comb begin
        s0_data_d = stage_shift(In,        Op,      Cnt[0],      1);
        s1_data_d = stage_shift(s0_data_q, s0_op_q, s0_cnt_q[1], 2);
        s2_data_d = stage_shift(s1_data_q, s1_op_q, s1_cnt_q[2], 4);
        s3_data_d = stage_shift(s2_data_q, s2_op_q, s2_cnt_q,    8);
    end

    assign in_ready  = ready0;
    assign out_valid = s3_valid_q;
    assign Out       = s3_data_q;
    assign out_tag   = s3_tag_q;
`ifdef SHIFT_PIPE_ZFLAG_EN
    assign out_zero  = s3_zero_q;
`endif

    // Stage 0: capture an accepted operation with the by-1 step applied.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s0_valid_q <= 1'b0;
            s0_data_q  <= '0;
            s0_cnt_q   <= '0;
            s0_op_q    <= '0;
            s0_tag_q   <= '0;
        end else if (ready0) begin
            s0_valid_q <= in_valid;
            if (in_valid) begin
                s0_data_q <= s0_data_d;
                s0_cnt_q  <= Cnt[3:1];
                s0_op_q   <= Op;
                s0_tag_q  <= in_tag;
            end
        end
    end

    // Stage 1: advance from stage 0 with the by-2 step applied.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid_q <= 1'b0;
            s1_data_q  <= '0;
            s1_cnt_q   <= '0;
            s1_op_q    <= '0;
            s1_tag_q   <= '0;
        end else if (ready1) begin
            s1_valid_q <= s0_valid_q;
            if (s0_valid_q) begin
                s1_data_q <= s1_data_d;
                s1_cnt_q  <= s0_cnt_q[3:2];
                s1_op_q   <= s0_op_q;
                s1_tag_q  <= s0_tag_q;
            end
        end
    end

    // Stage 2: advance from stage 1 with the by-4 step applied.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s2_valid_q <= 1'b0;
            s2_data_q  <= '0;
            s2_cnt_q   <= 1'b0;
            s2_op_q    <= '0;
            s2_tag_q   <= '0;
        end else if (ready2) begin
            s2_valid_q <= s1_valid_q;
            if (s1_valid_q) begin
                s2_data_q <= s2_data_d;
                s2_cnt_q  <= s1_cnt_q[3];
                s2_op_q   <= s1_op_q;
                s2_tag_q  <= s1_tag_q;
            end
        end
    end

    // Stage 3: final by-8 step; these registers drive the outputs directly.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s3_valid_q <= 1'b0;
            s3_data_q  <= '0;
            s3_tag_q   <= '0;
        end else if (ready3) begin
            s3_valid_q <= s2_valid_q;
            if (s2_valid_q) begin
                s3_data_q <= s3_data_d;
                s3_tag_q  <= s2_tag_q;
            end
        end
    end

`ifdef SHIFT_PIPE_ZFLAG_EN
    // Zero flag registered with the result so it stalls and clears like Out.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s3_zero_q <= 1'b0;
        end else if (ready3 && s2_valid_q) begin
            s3_zero_q <= (s3_data_d == '0);
        end
    end
`endif

endmodule
